// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants shared by the instruction decoder and encoder.
package rv_isa_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;
    localparam logic [1:0] ERR_OP    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CHECK = 2'b01,
        ST_WRITE = 2'b10
    } state_t;

    // True when v, read as two's complement, fits in an n-bit signed field.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned n);
        logic [31:0] hi;
        hi = 32'($signed(v) >>> (n - 1));
        return (hi == 32'h0000_0000) || (hi == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational RV32I packer: builds the instruction word and classifies errors.
module imm_pack
    import rv_isa_pkg::*;
(
    input  logic [6:0]  op,
    input  logic [2:0]  imm_src,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic [1:0]  err_code
);

    logic [2:0] exp_src;
    logic       op_known;

    // Immediate format the decoder would pick for this opcode.
    always_comb begin
        exp_src  = IMM_I;
        op_known = 1'b1;
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_JALR: exp_src = IMM_I;
            OP_STORE:                       exp_src = IMM_S;
            OP_BRANCH:                      exp_src = IMM_B;
            OP_JAL:                         exp_src = IMM_J;
            OP_AUIPC, OP_LUI:               exp_src = IMM_U;
            default:                        op_known = 1'b0;
        endcase
    end

    // Field packing and error classification; opcode mismatch beats alignment beats range.
    always_comb begin
        word     = {25'h0, op};
        err_code = ERR_NONE;
        if (!op_known || (imm_src != exp_src)) begin
            err_code = ERR_OP;
        end else begin
            case (imm_src)
                IMM_I: begin
                    if (op == OP_R) begin
                        word = {funct7, rs2, rs1, funct3, rd, op};
                    end else if ((op == OP_IMM) && (funct3[1:0] == 2'b01)) begin
                        // slli/srli/srai: shamt lives where rs2 would be
                        word = {funct7, imm[4:0], rs1, funct3, rd, op};
                        if (imm[31:5] != 27'h0) err_code = ERR_RANGE;
                    end else begin
                        word = {imm[11:0], rs1, funct3, rd, op};
                        if (!fits_signed(imm, 12)) err_code = ERR_RANGE;
                    end
                end
                IMM_S: begin
                    word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
                    if (!fits_signed(imm, 12)) err_code = ERR_RANGE;
                end
                IMM_B: begin
                    word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
                    if (imm[0])                  err_code = ERR_ALIGN;
                    else if (!fits_signed(imm, 13)) err_code = ERR_RANGE;
                end
                IMM_J: begin
                    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                    if (imm[0])                  err_code = ERR_ALIGN;
                    else if (!fits_signed(imm, 21)) err_code = ERR_RANGE;
                end
                IMM_U: begin
                    word = {imm[31:12], rd, op};
                    if (imm[11:0] != 12'h0) err_code = ERR_ALIGN;
                end
                default: err_code = ERR_OP;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: accepts fields, checks them, writes packed words to imem.
//
//   state    | meaning
//   ST_IDLE  | ready for a request (unless full or start)
//   ST_CHECK | captured item is packed and checked
//   ST_WRITE | mem_we strobe for the packed word
module instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        op,
    input  logic [2:0]        Imm_Src,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              full
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t      state, state_nxt;
    logic        accept;
    logic [6:0]  op_q, funct7_q;
    logic [2:0]  src_q, funct3_q;
    logic [4:0]  rd_q, rs1_q, rs2_q;
    logic [31:0] imm_q, word_pack;
    logic [1:0]  code_pack;

    assign in_ready = rst_n & (state == ST_IDLE) & ~full & ~start;
    assign accept   = in_valid & in_ready;
    // Reset forces state to IDLE asynchronously, which kills the strobe at once.
    assign mem_we   = (state == ST_WRITE) & ~start;

    imm_pack u_pack (
        .op       (op_q),
        .imm_src  (src_q),
        .rd       (rd_q),
        .rs1      (rs1_q),
        .rs2      (rs2_q),
        .funct3   (funct3_q),
        .funct7   (funct7_q),
        .imm      (imm_q),
        .word     (word_pack),
        .err_code (code_pack)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; start always returns to IDLE.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (accept) state_nxt = ST_CHECK;
                ST_CHECK: state_nxt = (code_pack == ERR_NONE) ? ST_WRITE : ST_IDLE;
                ST_WRITE: state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Capture request fields on accept; latch the packed word once it checks clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            src_q     <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            funct3_q  <= '0;
            funct7_q  <= '0;
            imm_q     <= '0;
            mem_wdata <= '0;
        end else begin
            if (accept) begin
                op_q     <= op;
                src_q    <= Imm_Src;
                rd_q     <= rd;
                rs1_q    <= rs1;
                rs2_q    <= rs2;
                funct3_q <= funct3;
                funct7_q <= funct7;
                imm_q    <= imm;
            end
            if ((state == ST_CHECK) && !start && (code_pack == ERR_NONE))
                mem_wdata <= word_pack;
        end
    end

    // Address counter, word count and sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= BASE;
            count    <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            full     <= 1'b0;
        end else if (start) begin
            mem_addr <= BASE;
            count    <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            full     <= 1'b0;
        end else if ((state == ST_CHECK) && (code_pack != ERR_NONE)) begin
            if (!err) err_code <= code_pack;
            err <= 1'b1;
        end else if (mem_we) begin
            mem_addr <= mem_addr + ADDR_W'(1);
            count    <= count + (ADDR_W + 1)'(1);
            if (mem_addr == LAST) full <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized + directed bench for instr_encoder against a transaction-level model.
module tb_instr_encoder;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [6:0]        op = '0;
    logic [2:0]        Imm_Src = '0;
    logic [4:0]        rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]        funct3 = '0;
    logic [6:0]        funct7 = '0;
    logic [31:0]       imm = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              err;
    logic [1:0]        err_code;
    logic              full;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .Imm_Src(Imm_Src), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .count(count), .err(err), .err_code(err_code), .full(full)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // staged stimulus, applied at the next falling edge
    logic        d_start = 0, d_valid = 0;
    logic [6:0]  d_op = 0, d_f7 = 0;
    logic [2:0]  d_src = 0, d_f3 = 0;
    logic [4:0]  d_rd = 0, d_rs1 = 0, d_rs2 = 0;
    logic [31:0] d_imm = 0;

    // model: phase 0 idle, 1 checking, 2 writing
    int          m_addr = 0, m_count = 0, m_phase = 0;
    logic        m_err = 0, m_full = 0;
    logic [1:0]  m_code = 0, m_res_code = 0;
    logic [31:0] m_res_word = 0;

    logic              seen_we, seen_ready, seen_full;
    logic [31:0]       seen_wdata;
    logic [ADDR_W-1:0] seen_addr;
    logic [ADDR_W:0]   seen_count;
    logic [1:0]        seen_code;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int src_of(input logic [6:0] o);
        case (o)
            7'h33, 7'h13, 7'h03, 7'h67: return 0;
            7'h23: return 1;
            7'h63: return 2;
            7'h6F: return 3;
            7'h17, 7'h37: return 4;
            default: return -1;
        endcase
    endfunction

    function automatic void model_encode(
        input logic [6:0] o, input logic [2:0] s, input logic [4:0] rdv, input logic [4:0] r1,
        input logic [4:0] r2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
        output logic [31:0] w, output logic [1:0] c);
        longint v;
        int     fmt;
        logic [31:0] regs;
        v    = longint'($signed(im));
        fmt  = src_of(o);
        w    = 32'(o);
        c    = 2'd0;
        regs = (32'(r1) << 15) | (32'(f3) << 12);
        if (fmt < 0 || int'(s) != fmt) begin
            c = 2'd3;
        end else if (fmt == 0 && o == 7'h33) begin
            w = (32'(f7) << 25) | (32'(r2) << 20) | regs | (32'(rdv) << 7) | 32'(o);
        end else if (fmt == 0 && o == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
            w = (32'(f7) << 25) | ((im % 32) << 20) | regs | (32'(rdv) << 7) | 32'(o);
            if (v < 0 || v > 31) c = 2'd1;
        end else if (fmt == 0) begin
            w = ((im % 4096) << 20) | regs | (32'(rdv) << 7) | 32'(o);
            if (v < -2048 || v > 2047) c = 2'd1;
        end else if (fmt == 1) begin
            w = (((im / 32) % 128) << 25) | (32'(r2) << 20) | regs | ((im % 32) << 7) | 32'(o);
            if (v < -2048 || v > 2047) c = 2'd1;
        end else if (fmt == 2) begin
            w = (((im / 4096) % 2) << 31) | (((im / 32) % 64) << 25) | (32'(r2) << 20) | regs
              | (((im / 2) % 16) << 8) | (((im / 2048) % 2) << 7) | 32'(o);
            if (im % 2 != 0) c = 2'd2;
            else if (v < -4096 || v > 4095) c = 2'd1;
        end else if (fmt == 3) begin
            w = (((im / 1048576) % 2) << 31) | (((im / 2) % 1024) << 21) | (((im / 2048) % 2) << 20)
              | (((im / 4096) % 256) << 12) | (32'(rdv) << 7) | 32'(o);
            if (im % 2 != 0) c = 2'd2;
            else if (v < -1048576 || v > 1048575) c = 2'd1;
        end else begin
            w = (im - (im % 4096)) | (32'(rdv) << 7) | 32'(o);
            if (im % 4096 != 0) c = 2'd2;
        end
    endfunction

    task automatic model_reset();
        m_addr = 0; m_count = 0; m_phase = 0; m_err = 0; m_full = 0; m_code = 0;
    endtask

    // One clock: drive staged inputs, compare every output, then advance the model.
    task automatic step();
        logic exp_ready, exp_we;
        @(negedge clk);
        start = d_start; in_valid = d_valid; op = d_op; Imm_Src = d_src; rd = d_rd;
        rs1 = d_rs1; rs2 = d_rs2; funct3 = d_f3; funct7 = d_f7; imm = d_imm;
        #1;
        exp_ready = (m_phase == 0) && !m_full && !d_start;
        exp_we    = (m_phase == 2) && !d_start;
        check("in_ready", in_ready, exp_ready);
        check("mem_we", mem_we, exp_we);
        check("mem_addr", mem_addr, m_addr);
        check("count", count, m_count);
        check("err", err, m_err);
        check("err_code", err_code, m_code);
        check("full", full, m_full);
        if (exp_we) check("mem_wdata", mem_wdata, m_res_word);
        seen_we = mem_we; seen_wdata = mem_wdata; seen_addr = mem_addr; seen_ready = in_ready;
        seen_full = full; seen_count = count; seen_code = err_code;
        @(posedge clk);
        if (d_start) begin
            model_reset();
        end else if (m_phase == 1) begin
            if (m_res_code != 0) begin
                if (!m_err) m_code = m_res_code;
                m_err = 1; m_phase = 0;
            end else m_phase = 2;
        end else if (m_phase == 2) begin
            m_count++;
            if (m_addr == DEPTH - 1) m_full = 1;
            m_addr = (m_addr + 1) % DEPTH;
            m_phase = 0;
        end else if (d_valid && exp_ready) begin
            model_encode(d_op, d_src, d_rd, d_rs1, d_rs2, d_f3, d_f7, d_imm, m_res_word, m_res_code);
            m_phase = 1;
        end
    endtask

    task automatic set_item(input logic [6:0] o, input logic [2:0] s, input logic [4:0] rdv,
                            input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] im);
        d_op = o; d_src = s; d_rd = rdv; d_rs1 = r1; d_rs2 = r2; d_f3 = f3; d_f7 = f7; d_imm = im;
    endtask

    // Send one item through the full three-cycle sequence and pin it to a literal.
    task automatic item(input string name, input logic [6:0] o, input logic [2:0] s,
                        input logic [4:0] rdv, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
                        input logic [31:0] lit_word, input logic [1:0] lit_code);
        logic [31:0] w;
        logic [1:0]  c;
        model_encode(o, s, rdv, r1, r2, f3, f7, im, w, c);
        check({name, "_model_code"}, c, lit_code);
        if (lit_code == 0) check({name, "_model_word"}, w, lit_word);
        set_item(o, s, rdv, r1, r2, f3, f7, im);
        d_valid = 1; step();
        d_valid = 0; step();
        step();
        check({name, "_we"}, seen_we, lit_code == 0);
        if (lit_code == 0) check({name, "_wdata"}, seen_wdata, lit_word);
    endtask

    task automatic pulse_start();
        d_start = 1; step(); d_start = 0;
    endtask

    task automatic reset_check(input string name);
        check({name, "_in_ready"}, in_ready, 0);
        check({name, "_mem_we"}, mem_we, 0);
        check({name, "_mem_addr"}, mem_addr, 0);
        check({name, "_mem_wdata"}, mem_wdata, 0);
        check({name, "_count"}, count, 0);
        check({name, "_err"}, err, 0);
        check({name, "_err_code"}, err_code, 0);
        check({name, "_full"}, full, 0);
    endtask

    logic [6:0] op_tab [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h17, 7'h37};

    initial begin
        repeat (2) @(negedge clk);
        #1 reset_check("reset");
        @(negedge clk); rst_n = 1;

        item("addi", 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 2'd0);
        check("addi_addr", seen_addr, 0);

        pulse_start();
        item("sw", 7'h23, 3'd1, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8, 32'h0051_2423, 2'd0);
        check("sw_addr", seen_addr, 0);
        item("beq", 7'h63, 3'd2, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 2'd0);
        check("beq_addr", seen_addr, 1);
        step();
        check("count_two", seen_count, 2);

        pulse_start();
        item("jal", 7'h6F, 3'd3, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0010_00EF, 2'd0);
        item("lui", 7'h37, 3'd4, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_51B7, 2'd0);
        item("auipc_low", 7'h17, 3'd4, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h0, 2'd2);
        step();
        check("auipc_code", seen_code, 2);
        check("auipc_addr", seen_addr, 2);

        pulse_start();
        item("addi_range", 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0, 2'd1);
        item("beq_src", 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4, 32'h0, 2'd3);
        step();
        check("sticky_code", seen_code, 1);
        pulse_start();
        item("beq_src2", 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4, 32'h0, 2'd3);
        step();
        check("op_code", seen_code, 3);

        // wrap in a 4-word memory
        pulse_start();
        for (int i = 0; i < DEPTH; i++)
            item("fill", 7'h13, 3'd0, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i + 1),
                 32'h0000_0013 | (32'(i + 1) << 20) | (32'(i) << 7), 2'd0);
        d_valid = 1; step(); step();
        d_valid = 0;
        check("wrap_full", seen_full, 1);
        check("wrap_addr", seen_addr, 0);
        check("wrap_ready", seen_ready, 0);
        check("wrap_count", seen_count, 4);
        pulse_start();
        step();
        check("restart_full", seen_full, 0);
        check("restart_count", seen_count, 0);
        check("restart_ready", seen_ready, 1);

        // start during the write cycle
        set_item(7'h13, 3'd0, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        d_valid = 1; step(); d_valid = 0; step();
        d_start = 1; step(); d_start = 0;
        check("start_write_we", seen_we, 0);
        step();
        check("start_write_count", seen_count, 0);

        // reset while checking
        d_valid = 1; step(); d_valid = 0;
        @(negedge clk); in_valid = 0; rst_n = 0;
        #1 reset_check("rst_check");
        model_reset();
        @(negedge clk); rst_n = 1;

        // reset while writing
        d_valid = 1; step(); d_valid = 0; step();
        @(negedge clk); in_valid = 0;
        #1 check("pre_rst_we", mem_we, 1);
        rst_n = 0;
        #1 reset_check("rst_write");
        model_reset();
        @(negedge clk); rst_n = 1;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int o_sel, kind;
            logic [6:0] o;
            o_sel = int'($urandom_range(0, 15));
            o = (o_sel < 9) ? op_tab[o_sel] : 7'($urandom);
            d_op = o;
            d_src = ($urandom_range(0, 7) != 0 && src_of(o) >= 0) ? 3'(src_of(o)) : 3'($urandom);
            d_rd = 5'($urandom); d_rs1 = 5'($urandom); d_rs2 = 5'($urandom);
            d_f3 = 3'($urandom); d_f7 = 7'($urandom);
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: d_imm = 32'($signed(int'($urandom_range(0, 80)) - 40));
                1: d_imm = $urandom;
                2: d_imm = 32'($signed(int'($urandom_range(0, 2200000)) - 1100000)) & 32'hFFFF_FFFE;
                default: d_imm = $urandom & 32'hFFFF_F000;
            endcase
            d_valid = ($urandom_range(0, 3) != 0);
            d_start = ($urandom_range(0, 49) == 0);
            step();
        end
        d_valid = 0; d_start = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
